pe_ctx_sequencer: RTL and testbench

//  Context sequencer for a row of NUM_PE processing elements. Stores NUM_CTX configuration

---
 rtl/pe_cfg_pkg.sv | 35 +++
 rtl/pe_ctx_mem.sv | 49 ++++
 rtl/pe_reg.sv | 30 +++
 rtl/pe_ctx_sequencer.sv | 139 +++++++++++++
 tb/tb_pe_ctx_sequencer.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pe_cfg_pkg.sv
// Shared definitions for the PE context sequencer.
//   state_t   : sequencer FSM states
//   CTRL_W    : width of one PE control word
//   *_LSB     : field offsets inside a control word {sel_op_0, sel_op_1, alu_op}
//   alu_op_t  : ALU operation codes
//   make_ctrl : packs the three fields into a control word
package pe_cfg_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int CTRL_W     = 8;
   localparam int ALU_OP_LSB = 0;
   localparam int SEL1_LSB   = 2;
   localparam int SEL0_LSB   = 5;

   typedef enum logic [1:0] {
      ALU_OR  = 2'd0,
      ALU_AND = 2'd1,
      ALU_XOR = 2'd2,
      ALU_SHL = 2'd3
   } alu_op_t;

   function automatic logic [CTRL_W-1:0] make_ctrl(input logic [2:0] sel0,
                                                    input logic [2:0] sel1,
                                                    input alu_op_t    op);
      return (CTRL_W'(sel0) << SEL0_LSB) |
             (CTRL_W'(sel1) << SEL1_LSB) |
             (CTRL_W'(op)   << ALU_OP_LSB);
   endfunction

endpackage

// File: rtl/pe_ctx_mem.sv
// Context store: NUM_CTX contexts x NUM_PE control words, built from flops.
//   clock, reset  : clock and asynchronous active-low reset (clears the store)
//   wr_en         : write wr_word into [wr_ctx][wr_pe]
//   rd_ctx        : context to read
//   rd_words      : all NUM_PE words of rd_ctx, PE i at [8*i+7:8*i] (combinational)
module pe_ctx_mem
   import pe_cfg_pkg::*;
#(
   parameter int NUM_PE  = 4,
   parameter int NUM_CTX = 4,
   localparam int CTX_W  = $clog2(NUM_CTX),
   localparam int PE_W   = $clog2(NUM_PE)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [CTX_W-1:0]         wr_ctx,
   input  logic [PE_W-1:0]          wr_pe,
   input  logic [CTRL_W-1:0]        wr_word,
   input  logic [CTX_W-1:0]         rd_ctx,
   output logic [NUM_PE*CTRL_W-1:0] rd_words
);

   logic [CTRL_W-1:0] mem [NUM_CTX][NUM_PE];

   // NOTE: the store is reset on purpose: after reset every PE must see an
   // all-zero control word, so this array cannot map onto a plain RAM macro.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int c = 0; c < NUM_CTX; c++) begin
            for (int p = 0; p < NUM_PE; p++) begin
               mem[c][p] <= '0;
            end
         end
      end else if (wr_en) begin
         mem[wr_ctx][wr_pe] <= wr_word;
      end
   end

   // NOTE: every combinational output gets a default before any conditional
   // or loop assignment so no path can leave it unassigned (no latch).
   always_comb begin
      rd_words = '0;
      for (int p = 0; p < NUM_PE; p++) begin
         rd_words[p*CTRL_W +: CTRL_W] = mem[rd_ctx][p];
      end
   end

endmodule

// File: rtl/pe_reg.sv
// Generic register with load enable and synchronous clear.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset, forces q to 0
//   en    : load d into q
//   clr   : clear q to 0 (wins over en)
//   d / q : data in / registered data out
module pe_reg #(
   parameter int W = 1
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         en,
   input  logic         clr,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // NOTE: sequential state is always written with <= so every register
   // samples the values from before the edge, independent of block order.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/pe_ctx_sequencer.sv
// Context sequencer for a row of NUM_PE processing elements.
// Steps through stored contexts, driving each PE's control word and enable
// for a programmed dwell time per context.
//   clock, reset          : clock, asynchronous active-low reset
//   cfg_valid/cfg_ready   : host config write handshake (ready only in IDLE)
//   cfg_ctx/cfg_pe/cfg_word : write target and data
//   start                 : run start pulse (IDLE only)
//   last_ctx/dwell/loop   : run settings, latched at start
//   stop                  : ends a looping run at the next wrap point
//   pe_en/pe_ctrl         : per-PE enable and control word
//   busy/done/cur_ctx     : run status
module pe_ctx_sequencer
   import pe_cfg_pkg::*;
#(
   parameter int NUM_PE  = 4,
   parameter int NUM_CTX = 4,
   parameter int CYC_W   = 4,
   localparam int CTX_W  = $clog2(NUM_CTX),
   localparam int PE_W   = $clog2(NUM_PE)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     cfg_valid,
   output logic                     cfg_ready,
   input  logic [CTX_W-1:0]         cfg_ctx,
   input  logic [PE_W-1:0]          cfg_pe,
   input  logic [CTRL_W-1:0]        cfg_word,
   input  logic                     start,
   input  logic [CTX_W-1:0]         last_ctx,
   input  logic [CYC_W-1:0]         dwell,
   input  logic                     loop,
   input  logic                     stop,
   output logic [NUM_PE-1:0]        pe_en,
   output logic [NUM_PE*CTRL_W-1:0] pe_ctrl,
   output logic                     busy,
   output logic                     done,
   output logic [CTX_W-1:0]         cur_ctx
);

   localparam logic [CYC_W-1:0] CNT_ONE = {{(CYC_W-1){1'b0}}, 1'b1};
   localparam logic [CTX_W-1:0] CTX_ONE = {{(CTX_W-1){1'b0}}, 1'b1};
   localparam int               SET_W   = CTX_W + CYC_W + 1;

   state_t                     state_q, state_d;
   logic [1:0]                 state_raw;
   logic [CYC_W-1:0]           cnt_q;
   logic [CTX_W-1:0]           cur_ctx_q;
   logic [SET_W-1:0]           run_set_q;
   logic [CTX_W-1:0]           last_q;
   logic [CYC_W-1:0]           dwell_q;
   logic                       loop_q;
   logic [CYC_W-1:0]           cnt_last;
   logic                       at_boundary;
   logic                       cnt_en, cnt_clr, ctx_en, ctx_clr, run_latch;
   logic [NUM_PE*CTRL_W-1:0]   ctx_words;

   pe_reg #(.W(2)) u_state_reg (
      .clock(clock), .reset(reset), .en(1'b1), .clr(1'b0),
      .d(state_d), .q(state_raw)
   );
   assign state_q = state_t'(state_raw);

   pe_reg #(.W(CYC_W)) u_cnt_reg (
      .clock(clock), .reset(reset), .en(cnt_en), .clr(cnt_clr),
      .d(cnt_q + CNT_ONE), .q(cnt_q)
   );

   pe_reg #(.W(CTX_W)) u_ctx_reg (
      .clock(clock), .reset(reset), .en(ctx_en), .clr(ctx_clr),
      .d(cur_ctx_q + CTX_ONE), .q(cur_ctx_q)
   );

   // Run settings are captured once at start so host changes mid-run are ignored.
   pe_reg #(.W(SET_W)) u_run_set_reg (
      .clock(clock), .reset(reset), .en(run_latch), .clr(1'b0),
      .d({last_ctx, dwell, loop}), .q(run_set_q)
   );
   assign {last_q, dwell_q, loop_q} = run_set_q;

   pe_ctx_mem #(.NUM_PE(NUM_PE), .NUM_CTX(NUM_CTX)) u_ctx_mem (
      .clock(clock), .reset(reset),
      .wr_en(cfg_valid & cfg_ready),
      .wr_ctx(cfg_ctx), .wr_pe(cfg_pe), .wr_word(cfg_word),
      .rd_ctx(cur_ctx_q), .rd_words(ctx_words)
   );

   // A dwell of 0 is treated as 1, so the last count value is 0 in both cases.
   assign cnt_last    = (dwell_q == '0) ? '0 : dwell_q - CNT_ONE;
   assign at_boundary = (cnt_q == cnt_last);

   always_comb begin
      state_d   = state_q;
      cnt_en    = 1'b0;
      cnt_clr   = 1'b0;
      ctx_en    = 1'b0;
      ctx_clr   = 1'b0;
      run_latch = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = RUN;
               run_latch = 1'b1;
               cnt_clr   = 1'b1;
               ctx_clr   = 1'b1;
            end
         end
         RUN: begin
            if (at_boundary) begin
               cnt_clr = 1'b1;
               // stop only matters here: the current context always finishes its dwell.
               if (cur_ctx_q < last_q) begin
                  ctx_en = 1'b1;
               end else if (loop_q && !stop) begin
                  ctx_clr = 1'b1;
               end else begin
                  state_d = DRAIN;
               end
            end else begin
               cnt_en = 1'b1;
            end
         end
         DRAIN: begin
            // cur_ctx still equals last_ctx here, so pe_ctrl holds the final context.
            state_d = IDLE;
            ctx_clr = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   // All outputs decode registered state only; no input reaches pe_en/pe_ctrl.
   assign cfg_ready = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DRAIN);
   assign pe_en     = {NUM_PE{state_q == RUN}};
   assign pe_ctrl   = busy ? ctx_words : '0;
   assign cur_ctx   = cur_ctx_q;

endmodule

// File: tb/tb_pe_ctx_sequencer.sv
// Self-checking bench for pe_ctx_sequencer: table of single-pass runs plus
// hand-written sequences for reset, looping/stop and write-with-start.
module tb_pe_ctx_sequencer;
   import pe_cfg_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        cfg_valid, cfg_ready;
   logic [1:0]  cfg_ctx, cfg_pe;
   logic [7:0]  cfg_word;
   logic        start, loop, stop;
   logic [1:0]  last_ctx;
   logic [3:0]  dwell;
   logic [3:0]  pe_en;
   logic [31:0] pe_ctrl;
   logic        busy, done;
   logic [1:0]  cur_ctx;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [1:0]  last;
      logic [3:0]  dwell;
      int          run_cyc;
      logic [31:0] first_ctrl;
      logic [31:0] drain_ctrl;
      bit          disturb;
   } vec_t;

   vec_t        vecs[7];
   logic [31:0] ctrl_lit[4];
   logic [31:0] exp_mem[4];

   pe_ctx_sequencer #(.NUM_PE(4), .NUM_CTX(4), .CYC_W(4)) dut (
      .clock(clock), .reset(reset),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_ctx(cfg_ctx), .cfg_pe(cfg_pe), .cfg_word(cfg_word),
      .start(start), .last_ctx(last_ctx), .dwell(dwell), .loop(loop), .stop(stop),
      .pe_en(pe_en), .pe_ctrl(pe_ctrl), .busy(busy), .done(done), .cur_ctx(cur_ctx)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [1:0] c, input logic [1:0] p, input logic [7:0] w);
      cfg_valid = 1'b1;
      cfg_ctx   = c;
      cfg_pe    = p;
      cfg_word  = w;
      tick();
      cfg_valid = 1'b0;
   endtask

   task automatic load_all();
      for (int c = 0; c < 4; c++)
         for (int p = 0; p < 4; p++)
            wr(2'(c), 2'(p), ctrl_lit[c][8*p +: 8]);
   endtask

   task automatic check_idle(input string name);
      check({name, "_busy"}, busy, 0);
      check({name, "_pe_en"}, pe_en, 0);
      check({name, "_ready"}, cfg_ready, 1);
      check({name, "_done"}, done, 0);
      check({name, "_ctx"}, cur_ctx, 0);
      check({name, "_ctrl"}, pe_ctrl, 0);
   endtask

   // One non-looping run: exact RUN length, context order, DRAIN, return to IDLE.
   task automatic run_vec(input vec_t v, input string name);
      int d;
      d = (v.dwell == 0) ? 1 : int'(v.dwell);
      last_ctx = v.last;
      dwell    = v.dwell;
      loop     = 1'b0;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      last_ctx = ~v.last;   // settings must have been latched at start
      dwell    = 4'd9;
      for (int c = 0; c < v.run_cyc; c++) begin
         check($sformatf("%s_en[%0d]", name, c), pe_en, 4'hF);
         check($sformatf("%s_ctx[%0d]", name, c), cur_ctx, c / d);
         check($sformatf("%s_ctrl[%0d]", name, c), pe_ctrl, exp_mem[c / d]);
         check($sformatf("%s_done[%0d]", name, c), done, 0);
         if (c == 0) check({name, "_first"}, pe_ctrl, v.first_ctrl);
         if (v.disturb && c == 2) begin
            check({name, "_ready_run"}, cfg_ready, 0);
            start     = 1'b1;
            last_ctx  = 2'd0;
            dwell     = 4'd1;
            cfg_valid = 1'b1;
            cfg_ctx   = 2'd0;
            cfg_pe    = 2'd0;
            cfg_word  = 8'hAA;
         end
         tick();
         start     = 1'b0;
         cfg_valid = 1'b0;
      end
      check({name, "_drain_done"}, done, 1);
      check({name, "_drain_en"}, pe_en, 0);
      check({name, "_drain_busy"}, busy, 1);
      check({name, "_drain_ctrl"}, pe_ctrl, v.drain_ctrl);
      tick();
      check_idle({name, "_end"});
   endtask

   initial begin
      vec_t z;
      int   seq[8];

      reset = 1'b1;
      {cfg_valid, cfg_ctx, cfg_pe, cfg_word} = '0;
      {start, last_ctx, dwell, loop, stop}   = '0;

      ctrl_lit[0] = 32'h64432201;
      ctrl_lit[1] = 32'h14131211;
      ctrl_lit[2] = 32'h24232221;
      ctrl_lit[3] = 32'h34333231;
      for (int c = 0; c < 4; c++) exp_mem[c] = 32'h0;

      //            last   dwell  cyc first_ctrl     drain_ctrl     disturb
      vecs[0] = '{2'd0, 4'd3,  3,  32'h64432201, 32'h64432201, 1'b0};
      vecs[1] = '{2'd2, 4'd2,  6,  32'h64432201, 32'h24232221, 1'b0};
      vecs[2] = '{2'd1, 4'd0,  2,  32'h64432201, 32'h14131211, 1'b0};
      vecs[3] = '{2'd3, 4'd2,  8,  32'h64432201, 32'h34333231, 1'b1};
      vecs[4] = '{2'd3, 4'd1,  4,  32'h64432201, 32'h34333231, 1'b0};
      vecs[5] = '{2'd0, 4'd1,  1,  32'h64432201, 32'h64432201, 1'b0};
      vecs[6] = '{2'd1, 4'd15, 30, 32'h64432201, 32'h14131211, 1'b0};

      // Reset state
      #2 reset = 1'b0;
      #3 check_idle("reset");
      tick();
      reset = 1'b1;
      tick();

      // Reset asserted mid-RUN clears everything including the store
      load_all();
      last_ctx = 2'd1; dwell = 4'd4; start = 1'b1;
      tick();
      start = 1'b0;
      check("mid_busy_before", busy, 1);
      tick();
      tick();
      #2 reset = 1'b0;
      #1 check_idle("mid_reset");
      tick();
      check_idle("mid_reset_edge");
      reset = 1'b1;
      tick();
      z = '{2'd0, 4'd2, 2, 32'h0, 32'h0, 1'b0};
      run_vec(z, "zero_run");

      // Table of single-pass runs
      load_all();
      for (int c = 0; c < 4; c++) exp_mem[c] = ctrl_lit[c];
      for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // stop in IDLE has no effect
      stop = 1'b1;
      tick();
      check("idle_stop_busy", busy, 0);
      stop = 1'b0;

      // Loop, last_ctx=1, dwell=1, stop raised while cur_ctx=0
      last_ctx = 2'd1; dwell = 4'd1; loop = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      stop  = 1'b1;
      check("loop1_ctx0", cur_ctx, 0);
      check("loop1_en0", pe_en, 4'hF);
      tick();
      check("loop1_ctx1", cur_ctx, 1);
      check("loop1_en1", pe_en, 4'hF);
      tick();
      check("loop1_done", done, 1);
      check("loop1_drain_en", pe_en, 0);
      stop = 1'b0;
      tick();
      check("loop1_idle", busy, 0);

      // Loop, dwell=2: wraps once; a stop that drops before the boundary is ignored
      seq = '{0, 0, 1, 1, 0, 0, 1, 1};
      last_ctx = 2'd1; dwell = 4'd2; loop = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      loop  = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("loop2_ctx[%0d]", i), cur_ctx, seq[i]);
         check($sformatf("loop2_ctrl[%0d]", i), pe_ctrl, exp_mem[seq[i]]);
         check($sformatf("loop2_en[%0d]", i), pe_en, 4'hF);
         if (i == 2 || i == 6) stop = 1'b1;
         if (i == 3) stop = 1'b0;
         tick();
      end
      check("loop2_done", done, 1);
      stop = 1'b0;
      tick();
      check("loop2_idle", busy, 0);

      // Write and start in the same IDLE cycle: new word visible in first RUN cycle
      cfg_valid = 1'b1;
      cfg_ctx   = 2'd0;
      cfg_pe    = 2'd2;
      cfg_word  = make_ctrl(3'd7, 3'd7, ALU_SHL);
      last_ctx  = 2'd0; dwell = 4'd1; start = 1'b1;
      tick();
      cfg_valid = 1'b0;
      start     = 1'b0;
      check("wr_start_byte", pe_ctrl[23:16], 8'hFF);
      check("wr_start_rest", pe_ctrl, 32'h64FF2201);
      check("wr_start_en", pe_en, 4'hF);
      tick();
      check("wr_start_done", done, 1);
      tick();
      check("wr_start_idle", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
